sxrom_mapper: RTL and testbench
===============================

# sxrom_mapper

Parametrised serial-load banked mapper (MMC1-class) for the cartridge mapper set, bound to the `map_bus.mapper` modport like the other generic mappers. It extends the direct-latch discrete mappers with several features:
- a 5-write serial shift interface
- a consecutive-write filter
- switchable PRG/CHR banking modes
- four mirroring modes
- optional WRAM gating

Bus writes are detected in the system clock domain from M2 edges rather than clocking registers on M2 directly.

## Interface
Parameters:
- `PRG_BANK_BITS`, 4: width of the 16 KB PRG bank number. Maximum 5.
- `CHR_BANK_BITS`, 5: width of the 4 KB CHR bank number.
- `WRAM_EN`, 1: when 1, `wram_ce` is driven for $6000-$7FFF; when 0, `wram_ce` is tied to 0.

Ports:
- `clk`  input  1  system clock. One clock; all state is in this domain.
- `rst_n`  input  1  reset, synchronous, active-low.
- `bus`  modport  `map_bus.mapper`.
  - Read from the modport: `m2`, `cpu_addr`, `cpu_rw`, `cpu_data_in`, `ppu_addr`, `ppu_rd`, `ppu_wr`, `chr_ram`, `sst_enable`.
  - Driven: `prg_addr`, `prg_oe`, `prg_we`, `wram_ce`, `cpu_data_oe`, `chr_addr`, `chr_ce`, `chr_oe`, `chr_we`, `ciram_ce`, `ciram_a10`, `audio`.

## Operation
M2 edge detection:
- `m2` is passed through a 2-flop synchroniser.
- While the synchronised M2 is high, `cpu_addr`, `cpu_rw` and `cpu_data_in` are captured every clk.
- A bus cycle ends on a detected falling edge of the synchronised M2. The captured values from the last high clk are used.

Serial port (write cycle with captured addr[15]=1 and rw=0):
- **Reset write (d[7]=1):**
  - sr=0, cnt=0, ctrl |= 5'h0C.
  - Never filtered.
- **Filtered write (d[7]=0):** ignored if the previous bus cycle was also a serial-port write (RMW double write).
- **Accepted write, cnt<4:** sr <= {d[0], sr[4:1]}, cnt++.
- **Accepted write, cnt==4 (fifth write):**
  - value = {d[0], sr[4:1]} is written to the register selected by captured addr[14:13].
  - 0 selects ctrl, 1 selects chr0, 2 selects chr1, 3 selects prg.
  - sr and cnt are then cleared.
- **`prev_wr` flag:** set by any bus cycle that is a serial-port write; cleared by any other bus cycle.
- **`sst_enable`=1:** bus cycles are ignored entirely. sr, cnt, registers and `prev_wr` are held.

Register fields:
- ctrl[1:0] mirroring:
  - 0: `ciram_a10`=0.
  - 1: `ciram_a10`=1.
  - 2: `ciram_a10`=ppu_addr[10] (vertical).
  - 3: `ciram_a10`=ppu_addr[11] (horizontal).
- ctrl[3:2] PRG mode:
  - 0/1: 32 KB, bank={prg[PB-1:1], cpu_addr[14]}.
  - 2: $8000 fixed to bank 0, $C000 selects prg.
  - 3: $8000 selects prg, $C000 fixed to bank all-ones.
- ctrl[4] CHR mode:
  - 1: 4 KB banks; ppu_addr[12] selects chr1, otherwise chr0.
  - 0: 8 KB, bank={chr0[CB-1:1], ppu_addr[12]}.
- prg[4]: WRAM disable (1 = disabled).
- Bank fields wider than the register are truncated. Fields narrower are zero-extended.

Mapping, all combinational from registers:
- `prg_addr` = ADDR_BITS'({prgbank, cpu_addr[13:0]}) for $8000+. For $6000-$7FFF it is ADDR_BITS'(cpu_addr[12:0]).
- `prg_oe` = cpu_addr[15] && cpu_rw. `prg_we`=0.
- `wram_ce` = WRAM_EN && !prg[4] && cpu_addr[15:13]==3'b011.
- `chr_addr` = ADDR_BITS'({chrbank, ppu_addr[11:0]}).
- `ciram_ce` = !ppu_addr[13]. `chr_ce` = `ciram_ce`. `chr_oe` = !ppu_rd.
- `chr_we` = chr_ram ? !ppu_wr : 0.
- `cpu_data_oe`=0, `audio`='0.

## Timing
- Reset (rst_n low at a clk edge):
  - sr=0, cnt=0, `prev_wr`=0, ctrl=5'h0C, chr0=chr1=prg=0.
  - Synchronisers are cleared, so no false edge is seen after reset.
- Outputs after reset:
  - `ciram_a10`=0.
  - PRG mode 3: $C000 maps to the last bank.
  - 8 KB CHR bank 0. WRAM enabled.
- Reset mid-sequence discards the partial shift.
- Latency:
  - Falling edge is detected 2-3 clk after the pin falls.
  - Register update lands on the next clk.
  - Mapping outputs reflect it in the same cycle the register updates.
- Reset write and fifth write in the same bus cycle cannot occur; d[7] takes priority.
- Requirement: clk ≥ 4× M2 frequency.

## Structure
- Shared package `mapper_pkg`:
  - `mirror_e` {ONE_A, ONE_B, VERT, HORZ}
  - `prg_mode_e`
  - `localparam CTRL_RESET = 5'h0C`
- Sub-module `m2_cycle_detect`:
  - inputs: M2 synchroniser, falling-edge pulse, address/data/rw capture.
  - outputs: one-clk `cycle_end` strobe with captured values.
  - Reusable by later mappers.

## Test plan
- **Reset defaults:** rst_n low 2 clk, read $C000 → `prg_addr` bank = 2^PRG_BANK_BITS−1; `ciram_a10`=0 for ppu_addr=$2400.
- **Serial load:** write $E000 with bit-serial 5'b00101 LSB-first → prg=5; read $8000 → `prg_addr`[17:14]=5.
- **Consecutive filter:** two back-to-back writes of $01 then $00 to $8000 → only one shift, cnt=1; a read cycle between them → cnt=2.
- **Reset write:** 3 partial writes, then write $80 → cnt=0, ctrl[3:2]=3. The next 5 writes load cleanly.
- **Mirroring/CHR modes:** ctrl=5'h12, chr1=7, ppu_addr=$1ABC → chr_addr={7, $ABC}. ppu_addr=$2800 → `ciram_a10`=0 (vertical, ppu_addr[10]=0).
- **sst_enable:** assert mid-sequence, issue 3 writes → sr/cnt unchanged. Deassert and finish → correct register.

Source files
------------

// File: rtl/sxrom_mapper_pkg.sv
// mapper_pkg: shared types and constants for the cartridge mapper set
package mapper_pkg;
  localparam int ADDR_BITS = 20;
  localparam logic [4:0] CTRL_RESET = 5'h0C;
  typedef enum logic [1:0] {ONE_A, ONE_B, VERT, HORZ} mirror_e;
  typedef enum logic [1:0] {PRG_32K_A, PRG_32K_B, PRG_FIX_FIRST, PRG_FIX_LAST} prg_mode_e;
  typedef enum logic [1:0] {REG_CTRL, REG_CHR0, REG_CHR1, REG_PRG} reg_sel_e;
endpackage

// File: rtl/sxrom_mapper_if.sv
// map_bus: cartridge bus between console side and a mapper
interface map_bus;
  import mapper_pkg::*;
  logic                 m2;
  logic [15:0]          cpu_addr;
  logic                 cpu_rw;
  logic [7:0]           cpu_data_in;
  logic [13:0]          ppu_addr;
  logic                 ppu_rd;
  logic                 ppu_wr;
  logic                 chr_ram;
  logic                 sst_enable;
  logic [ADDR_BITS-1:0] prg_addr;
  logic                 prg_oe;
  logic                 prg_we;
  logic                 wram_ce;
  logic                 cpu_data_oe;
  logic [ADDR_BITS-1:0] chr_addr;
  logic                 chr_ce;
  logic                 chr_oe;
  logic                 chr_we;
  logic                 ciram_ce;
  logic                 ciram_a10;
  logic [15:0]          audio;
  modport mapper (
    input  m2, cpu_addr, cpu_rw, cpu_data_in, ppu_addr, ppu_rd, ppu_wr, chr_ram, sst_enable,
    output prg_addr, prg_oe, prg_we, wram_ce, cpu_data_oe, chr_addr, chr_ce, chr_oe, chr_we,
           ciram_ce, ciram_a10, audio
  );
  modport slave (
    input  m2, cpu_addr, cpu_rw, cpu_data_in, ppu_addr, ppu_rd, ppu_wr, chr_ram, sst_enable,
    output prg_addr, prg_oe, prg_we, wram_ce, cpu_data_oe, chr_addr, chr_ce, chr_oe, chr_we,
           ciram_ce, ciram_a10, audio
  );
  modport master (
    output m2, cpu_addr, cpu_rw, cpu_data_in, ppu_addr, ppu_rd, ppu_wr, chr_ram, sst_enable,
    input  prg_addr, prg_oe, prg_we, wram_ce, cpu_data_oe, chr_addr, chr_ce, chr_oe, chr_we,
           ciram_ce, ciram_a10, audio
  );
endinterface

// File: rtl/sxrom_mapper_m2_cycle_detect.sv
// m2_cycle_detect: synchronise M2 and emit a one-clk strobe with the captured bus at each cycle end
module m2_cycle_detect (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_m2,
  input  logic [15:0] i_addr,
  input  logic        i_rw,
  input  logic [7:0]  i_data,
  output logic        o_cycle_end,
  output logic [15:0] o_addr,
  output logic        o_rw,
  output logic [7:0]  o_data
);
  logic [2:0]  r_m2;
  logic [15:0] r_addr;
  logic        r_rw;
  logic [7:0]  r_data;
  // two sync flops plus one delayed copy for falling-edge detection; cleared so reset never fakes an edge
  always_ff @(posedge clk) begin
    if (!rst_n) r_m2 <= '0;
    else r_m2 <= {r_m2[1:0], i_m2};
  end
  // track the bus while synchronised M2 is high so the last high clk's values survive the fall
  always_ff @(posedge clk) begin
    if (r_m2[1]) begin
      r_addr <= i_addr;
      r_rw   <= i_rw;
      r_data <= i_data;
    end
  end
  assign o_cycle_end = r_m2[2] & ~r_m2[1];
  assign o_addr      = r_addr;
  assign o_rw        = r_rw;
  assign o_data      = r_data;
endmodule

// File: rtl/sxrom_mapper.sv
// sxrom_mapper: MMC1-class serial-load banked mapper
module sxrom_mapper
  import mapper_pkg::*;
#(
  parameter int PRG_BANK_BITS = 4,
  parameter int CHR_BANK_BITS = 5,
  parameter int WRAM_EN       = 1
) (
  input logic     clk,
  input logic     rst_n,
  map_bus.mapper  bus
);
  localparam int PB = PRG_BANK_BITS;
  localparam int CB = CHR_BANK_BITS;
  logic        w_end;
  logic [15:0] w_addr;
  logic        w_rw;
  logic [7:0]  w_data;
  logic [4:0]  r_sr;
  logic [2:0]  r_cnt;
  logic        r_prev_wr;
  logic [4:0]  r_ctrl;
  logic [4:0]  r_chr0;
  logic [4:0]  r_chr1;
  logic [4:0]  r_prg;
  m2_cycle_detect u_cyc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_m2       (bus.m2),
    .i_addr     (bus.cpu_addr),
    .i_rw       (bus.cpu_rw),
    .i_data     (bus.cpu_data_in),
    .o_cycle_end(w_end),
    .o_addr     (w_addr),
    .o_rw       (w_rw),
    .o_data     (w_data)
  );
  logic       w_serial;
  logic       w_last;
  logic [4:0] w_val;
  reg_sel_e   w_sel;
  logic       w_unused;
  assign w_serial = w_addr[15] && !w_rw;
  assign w_last   = r_cnt == 3'd4;
  assign w_val    = {w_data[0], r_sr[4:1]};
  assign w_sel    = reg_sel_e'(w_addr[14:13]);
  assign w_unused = &{1'b0, w_data[6:1]};
  // serial port: reset writes always land, data writes are dropped when they follow another serial write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sr      <= '0;
      r_cnt     <= '0;
      r_prev_wr <= 1'b0;
      r_ctrl    <= CTRL_RESET;
      r_chr0    <= '0;
      r_chr1    <= '0;
      r_prg     <= '0;
    end else if (w_end && !bus.sst_enable) begin
      r_prev_wr <= w_serial;
      if (w_serial && w_data[7]) begin
        r_sr   <= '0;
        r_cnt  <= '0;
        r_ctrl <= r_ctrl | CTRL_RESET;
      end else if (w_serial && !r_prev_wr) begin
        r_sr  <= w_last ? 5'd0 : w_val;
        r_cnt <= w_last ? 3'd0 : r_cnt + 3'd1;
        if (w_last && w_sel == REG_CTRL) r_ctrl <= w_val;
        if (w_last && w_sel == REG_CHR0) r_chr0 <= w_val;
        if (w_last && w_sel == REG_CHR1) r_chr1 <= w_val;
        if (w_last && w_sel == REG_PRG)  r_prg  <= w_val;
      end
    end
  end
  mirror_e       w_mirror;
  prg_mode_e     w_mode;
  logic [PB-1:0] w_prg_reg;
  logic [PB-1:0] w_prg_bank;
  logic [CB-1:0] w_chr0;
  logic [CB-1:0] w_chr1;
  logic [CB-1:0] w_chr_bank;
  logic          w_a14;
  assign w_mirror   = mirror_e'(r_ctrl[1:0]);
  assign w_mode     = prg_mode_e'(r_ctrl[3:2]);
  assign w_prg_reg  = PB'(r_prg);
  assign w_chr0     = CB'(r_chr0);
  assign w_chr1     = CB'(r_chr1);
  assign w_a14      = bus.cpu_addr[14];
  assign w_prg_bank = (w_mode == PRG_FIX_FIRST) ? (w_a14 ? w_prg_reg : '0) :
                      (w_mode == PRG_FIX_LAST)  ? (w_a14 ? '1 : w_prg_reg) :
                      {w_prg_reg[PB-1:1], w_a14};
  assign w_chr_bank = r_ctrl[4] ? (bus.ppu_addr[12] ? w_chr1 : w_chr0) :
                      {w_chr0[CB-1:1], bus.ppu_addr[12]};
  assign bus.prg_addr    = bus.cpu_addr[15] ? ADDR_BITS'({w_prg_bank, bus.cpu_addr[13:0]}) :
                                              ADDR_BITS'(bus.cpu_addr[12:0]);
  assign bus.prg_oe      = bus.cpu_addr[15] && bus.cpu_rw;
  assign bus.prg_we      = 1'b0;
  assign bus.wram_ce     = (WRAM_EN != 0) && !r_prg[4] && bus.cpu_addr[15:13] == 3'b011;
  assign bus.cpu_data_oe = 1'b0;
  assign bus.chr_addr    = ADDR_BITS'({w_chr_bank, bus.ppu_addr[11:0]});
  assign bus.ciram_ce    = !bus.ppu_addr[13];
  assign bus.chr_ce      = !bus.ppu_addr[13];
  assign bus.chr_oe      = !bus.ppu_rd;
  assign bus.chr_we      = bus.chr_ram ? !bus.ppu_wr : 1'b0;
  assign bus.ciram_a10   = (w_mirror == ONE_A) ? 1'b0 :
                           (w_mirror == ONE_B) ? 1'b1 :
                           (w_mirror == VERT)  ? bus.ppu_addr[10] : bus.ppu_addr[11];
  assign bus.audio       = '0;
endmodule

// File: tb/tb_sxrom_mapper.sv
// tb_sxrom_mapper: directed self-checking bench for the serial-load mapper
module tb_sxrom_mapper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  map_bus bus();
  sxrom_mapper #(.PRG_BANK_BITS(4), .CHR_BANK_BITS(5), .WRAM_EN(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask
  task automatic cyc(input logic [15:0] a, input logic rw, input logic [7:0] d);
    @(negedge clk);
    bus.cpu_addr = a;
    bus.cpu_rw = rw;
    bus.cpu_data_in = d;
    bus.m2 = 1'b1;
    repeat (6) @(negedge clk);
    bus.m2 = 1'b0;
    repeat (6) @(negedge clk);
  endtask
  task automatic rd();
    cyc(16'h8000, 1'b1, 8'h00);
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(a, 1'b0, d);
  endtask
  task automatic write5(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) begin
      rd();
      wr(a, {7'd0, v[i]});
    end
  endtask
  task automatic cpu(input logic [15:0] a);
    bus.cpu_addr = a;
    bus.cpu_rw = 1'b1;
    #1;
  endtask
  task automatic ppu(input logic [13:0] a);
    bus.ppu_addr = a;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    bus.m2 = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_rw = 1'b1;
    bus.cpu_data_in = '0;
    bus.ppu_addr = '0;
    bus.ppu_rd = 1'b1;
    bus.ppu_wr = 1'b1;
    bus.chr_ram = 1'b0;
    bus.sst_enable = 1'b0;
    do_reset();
    cpu(16'hC000); chk("rst_c000", bus.prg_addr, 32'h3C000);
    chk("rst_prg_oe", bus.prg_oe, 1);
    cpu(16'h8123); chk("rst_8123", bus.prg_addr, 32'h00123);
    ppu(14'h2400); chk("rst_a10", bus.ciram_a10, 0);
    ppu(14'h1ABC); chk("rst_chr8k", bus.chr_addr, 32'h01ABC);
    cpu(16'h6000); chk("rst_wram", bus.wram_ce, 1);
    write5(16'hE000, 5'd5);
    cpu(16'h8000); chk("ser_prg5", bus.prg_addr, 32'h14000);
    write5(16'h8000, 5'h12);
    write5(16'hC000, 5'd7);
    ppu(14'h1ABC); chk("chr1_4k", bus.chr_addr, 32'h07ABC);
    ppu(14'h2800); chk("vert_2800", bus.ciram_a10, 0);
    ppu(14'h2400); chk("vert_2400", bus.ciram_a10, 1);
    cpu(16'hC000); chk("p32_c000", bus.prg_addr, 32'h14000);
    cpu(16'h8000); chk("p32_8000", bus.prg_addr, 32'h10000);
    rd();
    wr(16'h8000, 8'h01);
    wr(16'h8000, 8'h00);
    chk("filt_cnt1", dut.r_cnt, 1);
    rd();
    wr(16'h8000, 8'h00);
    chk("filt_cnt2", dut.r_cnt, 2);
    rd();
    wr(16'h8000, 8'h01);
    chk("filt_cnt3", dut.r_cnt, 3);
    wr(16'h8000, 8'h80);
    chk("rstw_cnt0", dut.r_cnt, 0);
    cpu(16'hC000); chk("rstw_c000", bus.prg_addr, 32'h3C000);
    cpu(16'h8000); chk("rstw_8000", bus.prg_addr, 32'h14000);
    ppu(14'h2400); chk("rstw_mir", bus.ciram_a10, 1);
    write5(16'hA000, 5'd3);
    ppu(14'h0ABC); chk("chr0_4k", bus.chr_addr, 32'h03ABC);
    ppu(14'h1ABC); chk("chr1_keep", bus.chr_addr, 32'h07ABC);
    write5(16'h8000, 5'h03);
    ppu(14'h2800); chk("horz_2800", bus.ciram_a10, 1);
    ppu(14'h2400); chk("horz_2400", bus.ciram_a10, 0);
    ppu(14'h1ABC); chk("chr8k_hi", bus.chr_addr, 32'h03ABC);
    ppu(14'h0ABC); chk("chr8k_lo", bus.chr_addr, 32'h02ABC);
    rd(); wr(16'hE000, 8'h01);
    rd(); wr(16'hE000, 8'h01);
    chk("sst_pre_cnt", dut.r_cnt, 2);
    bus.sst_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd();
      wr(16'hE000, 8'h01);
    end
    chk("sst_cnt", dut.r_cnt, 2);
    chk("sst_sr", dut.r_sr, 5'h18);
    bus.sst_enable = 1'b0;
    rd(); wr(16'hE000, 8'h00);
    rd(); wr(16'hE000, 8'h01);
    rd(); wr(16'hE000, 8'h00);
    cpu(16'hC000); chk("sst_c000", bus.prg_addr, 32'h2C000);
    cpu(16'h8000); chk("sst_8000", bus.prg_addr, 32'h28000);
    cpu(16'h6123); chk("wram_addr", bus.prg_addr, 32'h00123);
    chk("wram_on", bus.wram_ce, 1);
    chk("wram_oe", bus.prg_oe, 0);
    write5(16'hE000, 5'h10);
    cpu(16'h6000); chk("wram_off", bus.wram_ce, 0);
    ppu(14'h2000); chk("ciram_ce_hi", bus.ciram_ce, 0);
    chk("chr_ce_hi", bus.chr_ce, 0);
    ppu(14'h0000); chk("ciram_ce_lo", bus.ciram_ce, 1);
    bus.ppu_rd = 1'b0; #1; chk("chr_oe", bus.chr_oe, 1);
    bus.ppu_rd = 1'b1;
    bus.chr_ram = 1'b1; bus.ppu_wr = 1'b0; #1; chk("chr_we_ram", bus.chr_we, 1);
    bus.chr_ram = 1'b0; #1; chk("chr_we_rom", bus.chr_we, 0);
    bus.ppu_wr = 1'b1;
    chk("prg_we", bus.prg_we, 0);
    chk("data_oe", bus.cpu_data_oe, 0);
    chk("audio", bus.audio, 0);
    rd(); wr(16'h8000, 8'h01);
    rd(); wr(16'h8000, 8'h01);
    chk("mid_cnt", dut.r_cnt, 2);
    do_reset();
    chk("mid_rst_cnt", dut.r_cnt, 0);
    cpu(16'hC000); chk("mid_c000", bus.prg_addr, 32'h3C000);
    cpu(16'h8000); chk("mid_8000", bus.prg_addr, 32'h00000);
    ppu(14'h2400); chk("mid_a10", bus.ciram_a10, 0);
    write5(16'h8000, 5'h01);
    ppu(14'h2000); chk("one_b", bus.ciram_a10, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
